// File: rtl/lfsr_seed_ctrl.sv
// lfsr_seed_ctrl
// Captures a seed and a word count on start, loads a 16-bit Fibonacci LFSR
// (taps 16,14,13,11) and streams exactly `count` pseudo-random words over a
// valid/ready handshake, then pulses done for one cycle.
// All outputs are registered: they are computed from the next-state values
// so that they line up with the state register on every clock edge.

module lfsr_seed_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      seed_in,
  input  logic [CNT_W-1:0] count,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Seed substituted when an all-zero seed is requested (all-zero locks up).
  localparam logic [15:0] SAFE_SEED = 16'hACE1;

  localparam logic [CNT_W-1:0] REM_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // One Fibonacci step, taps 16,14,13,11 (maximal length).
  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
  endfunction

  // Replace the lock-up value with the safe default seed.
  function automatic logic [15:0] guard_seed(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'h0000) begin
      result = SAFE_SEED;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // State and datapath registers.
  state_t           state_r;
  logic [15:0]      seed_r;
  logic [15:0]      lfsr_r;
  logic [CNT_W-1:0] rem_r;

  // Next-state values.
  state_t           state_s;
  logic [15:0]      seed_s;
  logic [15:0]      lfsr_s;
  logic [CNT_W-1:0] rem_s;

  // Next values of the registered outputs.
  logic [15:0]      out_data_s;
  logic             out_valid_s;
  logic             busy_s;
  logic             done_s;

  // Output registers.
  logic [15:0]      out_data_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             done_r;

  // Next-state and datapath update logic for the burst sequencer.
  always_comb begin
    state_s = state_r;
    seed_s  = seed_r;
    lfsr_s  = lfsr_r;
    rem_s   = rem_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          seed_s = guard_seed(seed_in);
          rem_s  = count;
          if (count == REM_ZERO) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        lfsr_s  = seed_r;
        state_s = ST_RUN;
      end
      ST_RUN: begin
        if (out_ready) begin
          lfsr_s = lfsr_step(lfsr_r);
          rem_s  = rem_r - REM_ONE;
          // rem_r is never zero here; treating zero as terminal keeps a
          // corrupted counter from producing a runaway burst.
          if ((rem_r == REM_ONE) || (rem_r == REM_ZERO)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values derived from the state being entered on the next edge.
  always_comb begin
    out_valid_s = 1'b0;
    out_data_s  = 16'h0000;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_LOAD: begin
        busy_s = 1'b1;
      end
      ST_RUN: begin
        busy_s      = 1'b1;
        out_valid_s = 1'b1;
        out_data_s  = lfsr_s;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      seed_r  <= 16'h0000;
      lfsr_r  <= 16'h0000;
      rem_r   <= REM_ZERO;
    end else begin
      state_r <= state_s;
      seed_r  <= seed_s;
      lfsr_r  <= lfsr_s;
      rem_r   <= rem_s;
    end
  end

  // Registered outputs; reset clears them in the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= 16'h0000;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

  lfsr_seed_ctrl_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .out_data  (out_data_r),
    .out_valid (out_valid_r),
    .busy      (busy_r),
    .done      (done_r)
  );

endmodule

// Output consistency checker for lfsr_seed_ctrl.
module lfsr_seed_ctrl_chk (
  input logic        clk,
  input logic        rst,
  input logic [15:0] out_data,
  input logic        out_valid,
  input logic        busy,
  input logic        done
);

  // Data bus is quiet whenever no word is offered.
  a_data_quiet : assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> (out_data == 16'h0000));

  // A done pulse or a valid word only appears while busy.
  a_done_busy : assert property (@(posedge clk) disable iff (rst)
    done |-> busy);
  a_valid_busy : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> busy);

  // done and out_valid never overlap, and done lasts a single cycle.
  a_done_excl : assert property (@(posedge clk) disable iff (rst)
    done |-> !out_valid);
  a_done_pulse : assert property (@(posedge clk) disable iff (rst)
    done |=> !done);

endmodule

// File: tb/tb_lfsr_seed_ctrl.sv
// Directed bench for lfsr_seed_ctrl. Each cycle check packs
// {out_valid, busy, done, out_data} and compares against hand-computed values.
`timescale 1ns/1ps

module tb_lfsr_seed_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] seed_in;
  logic [7:0]  count;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  lfsr_seed_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed_in   (seed_in),
    .count     (count),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, then compare outputs of the new cycle.
  task automatic cyc(input string tag, input logic v, input logic b,
                     input logic d, input logic [15:0] data);
    logic [18:0] obs;
    logic [18:0] exp;
    @(posedge clk);
    #1;
    obs = {out_valid, busy, done, out_data};
    exp = {v, b, d, data};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed v/b/d/data=%b/%b/%b/%h expected %b/%b/%b/%h",
             tag, obs[18], obs[17], obs[16], obs[15:0],
             exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    seed_in   = 16'h0000;
    count     = 8'd0;
    out_ready = 1'b1;

    // Reset
    cyc("reset0", 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc("reset1", 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    cyc("idle0", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Burst ACE1, count 3, ready held high
    start = 1'b1; seed_in = 16'hACE1; count = 8'd3;
    cyc("a_load", 1'b0, 1'b1, 1'b0, 16'h0000);
    start = 1'b0;
    cyc("a_w0", 1'b1, 1'b1, 1'b0, 16'hACE1);
    cyc("a_w1", 1'b1, 1'b1, 1'b0, 16'h59C3);
    cyc("a_w2", 1'b1, 1'b1, 1'b0, 16'hB387);
    cyc("a_done", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("a_idle", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Same burst with one stall on the second word
    start = 1'b1;
    cyc("b_load", 1'b0, 1'b1, 1'b0, 16'h0000);
    start = 1'b0;
    cyc("b_w0", 1'b1, 1'b1, 1'b0, 16'hACE1);
    cyc("b_w1", 1'b1, 1'b1, 1'b0, 16'h59C3);
    out_ready = 1'b0;
    cyc("b_w1_hold", 1'b1, 1'b1, 1'b0, 16'h59C3);
    out_ready = 1'b1;
    cyc("b_w2", 1'b1, 1'b1, 1'b0, 16'hB387);
    cyc("b_done", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("b_idle", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Zero seed is replaced by ACE1
    start = 1'b1; seed_in = 16'h0000; count = 8'd1;
    cyc("c_load", 1'b0, 1'b1, 1'b0, 16'h0000);
    start = 1'b0;
    cyc("c_w0", 1'b1, 1'b1, 1'b0, 16'hACE1);
    cyc("c_done", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("c_idle", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Seed 0001, count 2
    start = 1'b1; seed_in = 16'h0001; count = 8'd2;
    cyc("d_load", 1'b0, 1'b1, 1'b0, 16'h0000);
    start = 1'b0;
    cyc("d_w0", 1'b1, 1'b1, 1'b0, 16'h0001);
    cyc("d_w1", 1'b1, 1'b1, 1'b0, 16'h0002);
    cyc("d_done", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("d_idle", 1'b0, 1'b0, 1'b0, 16'h0000);

    // count 0 goes straight to DONE
    start = 1'b1; seed_in = 16'h5555; count = 8'd0;
    cyc("e_done", 1'b0, 1'b1, 1'b1, 16'h0000);
    start = 1'b0;
    cyc("e_idle", 1'b0, 1'b0, 1'b0, 16'h0000);

    // start during RUN is ignored
    start = 1'b1; seed_in = 16'hACE1; count = 8'd3;
    cyc("f_load", 1'b0, 1'b1, 1'b0, 16'h0000);
    start = 1'b0;
    cyc("f_w0", 1'b1, 1'b1, 1'b0, 16'hACE1);
    start = 1'b1; seed_in = 16'h1234; count = 8'd7;
    cyc("f_w1", 1'b1, 1'b1, 1'b0, 16'h59C3);
    start = 1'b0;
    cyc("f_w2", 1'b1, 1'b1, 1'b0, 16'hB387);
    cyc("f_done", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("f_idle0", 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc("f_idle1", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Held start re-arms on the first IDLE cycle after DONE
    start = 1'b1; seed_in = 16'h0001; count = 8'd1;
    cyc("g_load0", 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc("g_w0", 1'b1, 1'b1, 1'b0, 16'h0001);
    cyc("g_done0", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("g_idle", 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc("g_load1", 1'b0, 1'b1, 1'b0, 16'h0000);
    start = 1'b0;
    cyc("g_w1", 1'b1, 1'b1, 1'b0, 16'h0001);
    cyc("g_done1", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("g_idle1", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset mid-burst aborts with no done pulse
    start = 1'b1; seed_in = 16'hACE1; count = 8'd5;
    cyc("h_load", 1'b0, 1'b1, 1'b0, 16'h0000);
    start = 1'b0;
    cyc("h_w0", 1'b1, 1'b1, 1'b0, 16'hACE1);
    cyc("h_w1", 1'b1, 1'b1, 1'b0, 16'h59C3);
    rst = 1'b1;
    cyc("h_rst", 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    cyc("h_idle0", 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc("h_idle1", 1'b0, 1'b0, 1'b0, 16'h0000);
    start = 1'b1; seed_in = 16'h0001; count = 8'd2;
    cyc("h_load2", 1'b0, 1'b1, 1'b0, 16'h0000);
    start = 1'b0;
    cyc("h_n0", 1'b1, 1'b1, 1'b0, 16'h0001);
    cyc("h_n1", 1'b1, 1'b1, 1'b0, 16'h0002);
    cyc("h_done", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("h_idle2", 1'b0, 1'b0, 1'b0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_seed_ctrl.md
# lfsr_seed_ctrl

Controller that sequences the 16-bit seed register and a 16-bit Fibonacci LFSR to produce a burst of pseudo-random words. On `start` it captures a seed and a word count, loads the LFSR, and then streams exactly `count` words over a valid/ready handshake. It pulses `done` after the last word. It sits between the test-pattern/control logic and any consumer of random words.

## Interface
Parameters:
- CNT_W, 8, width of the burst-length counter (max burst 2^CNT_W − 1)

Ports:
- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous, active-high reset
- start  in  1  request a burst; sampled only in IDLE
- seed_in  in  16  seed captured on accepted start
- count  in  CNT_W  number of words in the burst; captured on accepted start
- out_ready  in  1  consumer can accept out_data this cycle
- out_data  out  16  current LFSR word; 16'h0000 whenever out_valid=0
- out_valid  out  1  out_data is a valid burst word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse marking end of burst

## Operation
- Internal registers: `seed_q[15:0]` (load-enabled seed register), `lfsr_q[15:0]`, `rem_q[CNT_W-1:0]`, 2-bit state.
- LFSR step: lfsr_next = {lfsr_q[14:0], lfsr_q[15]^lfsr_q[13]^lfsr_q[12]^lfsr_q[10]} (taps 16,14,13,11; maximal length, period 65535).
- Zero-seed guard: if seed_in==16'h0000 on an accepted start, seed_q loads 16'hACE1 (all-zero is the lock-up state).
- States:
  - IDLE: busy=0. If start=1: seed_q<=seed_in (with guard), rem_q<=count. Next state is LOAD, or DONE if count==0.
  - LOAD: lfsr_q<=seed_q; next RUN. out_valid=0.
  - RUN: out_valid=1, out_data=lfsr_q. On out_valid&out_ready: lfsr_q<=lfsr_next, rem_q<=rem_q−1. If rem_q==1 at the handshake, go to DONE. Without a handshake, lfsr_q, rem_q and out_data hold.
  - DONE: done=1 for exactly this cycle, busy=1; next IDLE.
- start outside IDLE is ignored. It is not queued, and seed_q/rem_q are unchanged.
- A start seen in IDLE is accepted even if start stays high. Holding start high re-arms a new burst on the first IDLE cycle after DONE.
- out_ready is ignored outside RUN.
- seed_q retains its value after the burst. lfsr_q retains the last advanced value; it is not visible because out_data=0 outside RUN.

## Timing
- Reset (rst=1 at a clock edge): state=IDLE; seed_q, lfsr_q, rem_q = 0; out_valid=0, out_data=0, busy=0, done=0. Reset mid-burst aborts immediately with no done pulse.
- start accepted at edge T: busy=1 from T+1 (LOAD). First out_valid at T+2 with out_data=effective seed.
- With out_ready held high: one word per cycle. Last handshake at T+1+count. done at T+2+count. IDLE (busy=0) at T+3+count. The earliest next start acceptance is at that edge.
- count==0: busy/done high at T+1 (DONE), IDLE at T+2. No out_valid ever.
- Backpressure: each out_ready=0 cycle in RUN stretches the burst by one cycle. Word order is unchanged.
- Word k of a burst (k=0..count−1) = effective seed advanced k LFSR steps, independent of stall pattern.

## Test plan
- Reset, then start with seed_in=16'hACE1, count=3, out_ready=1 -> out_data 16'hACE1, 16'h59C3, 16'hB387 on consecutive cycles from T+2. done at T+5, busy low at T+6.
- Same burst with out_ready=0 on the 2nd RUN cycle -> 16'h59C3 held for two cycles with out_valid=1. Sequence unchanged. done one cycle later (T+6).
- seed_in=16'h0000, count=1 -> single word 16'hACE1, then done. Also check seed_in=16'h0001, count=2 -> 16'h0001, 16'h0002.
- count=0 -> no out_valid, busy=1 and done=1 at T+1, IDLE at T+2.
- start pulsed with seed_in=16'h1234 during RUN of an ACE1 burst -> ignored. The ACE1 sequence continues and the following burst still needs a fresh start in IDLE.
- rst asserted during RUN after two words -> next cycle all outputs 0, state IDLE, no done. A subsequent start runs a clean burst from the new seed.
